// File: rtl/btb_pkg.sv
// Shared types and address-slice constants for the BTB write side.
// The update entry layout here is the one the BTB write port consumes.
package btb_pkg;

    localparam int BTB_ADDR_W        = 64;
    localparam int BTB_INDEX_W       = 2;
    localparam int BYTE_OFFSET_WIDTH = 2;
    localparam int BTB_BIA_W         = BTB_ADDR_W - BTB_INDEX_W - BYTE_OFFSET_WIDTH;
    localparam int BTB_WAYS          = 4;
    localparam int BTB_WAY_W         = $clog2(BTB_WAYS);
    localparam int BTB_FIFO_DEPTH    = 4;

    // PC bit positions of the set index and the branch-instruction-address tag
    localparam int INDEX_LSB = BYTE_OFFSET_WIDTH;
    localparam int INDEX_MSB = INDEX_LSB + BTB_INDEX_W - 1;
    localparam int BIA_LSB   = INDEX_MSB + 1;
    localparam int BIA_MSB   = BTB_ADDR_W - 1;

    typedef struct packed {
        logic [BTB_WAY_W-1:0]   way;
        logic [BTB_INDEX_W-1:0] index;
        logic [BTB_BIA_W-1:0]   bia;
        logic [BTB_ADDR_W-1:0]  target;
    } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of BTB update entries. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
// Push and pop in the same cycle are both honoured when not full.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = BTB_FIFO_DEPTH
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  btb_upd_t data_i,
    input  logic     pop_i,
    output btb_upd_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    btb_upd_t        mem_q [DEPTH];
    btb_upd_t        mem_d [DEPTH];
    logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;
    logic            do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Next-state for storage and pointers; overflow/underflow requests are dropped
    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and storage registers; reset only empties, storage keeps stale data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/btb_update_unit.sv
// BTB update unit: detects mispredictions from execute-stage resolutions,
// produces a registered fetch redirect, and queues BTB writes that drain
// whenever fetch is not stalled.
// Optional performance counters are built when BTB_UPD_PERF_EN is defined;
// otherwise both counter ports are tied to zero.
//
// Handshake: a resolution transfers on a cycle where resolve_valid_i and
// resolve_ready_o are both high; resolve_ready_o depends only on FIFO
// fullness and does not anticipate a same-cycle pop.
module btb_update_unit
    import btb_pkg::*;
#(
    parameter int ADDR_WIDTH  = BTB_ADDR_W,
    parameter int INDEX_WIDTH = BTB_INDEX_W,
    parameter int BIA_WIDTH   = BTB_BIA_W,
    parameter int N           = BTB_WAYS,
    parameter int FIFO_DEPTH  = BTB_FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   stall_fetch_i,
    input  logic                   resolve_valid_i,
    output logic                   resolve_ready_o,
    input  logic [ADDR_WIDTH-1:0]  resolve_pc_i,
    input  logic                   resolve_taken_i,
    input  logic [ADDR_WIDTH-1:0]  resolve_target_i,
    input  logic                   pred_hit_i,
    input  logic [$clog2(N)-1:0]   pred_way_i,
    input  logic [ADDR_WIDTH-1:0]  pred_target_i,
    output logic                   mispredict_o,
    output logic [ADDR_WIDTH-1:0]  redirect_pc_o,
    output logic                   branch_taken_o,
    output logic [$clog2(N)-1:0]   way_write_o,
    output logic [INDEX_WIDTH-1:0] index_write_o,
    output logic [BIA_WIDTH-1:0]   bia_write_o,
    output logic [ADDR_WIDTH-1:0]  target_addr_o,
    output logic [31:0]            resolved_cnt_o,
    output logic [31:0]            mispredict_cnt_o
);

    logic                  fifo_full, fifo_empty;
    logic                  accept, is_mispredict, push, pop;
    btb_upd_t              push_entry, head_entry;
    logic                  mispredict_q, mispredict_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    // Acceptance, misprediction classification and the entry to enqueue
    always_comb begin
        accept        = resolve_valid_i & ~fifo_full;
        is_mispredict = (resolve_taken_i != pred_hit_i) |
                        (resolve_taken_i & pred_hit_i & (resolve_target_i != pred_target_i));
        // Correct taken hits are still written so the BTB refreshes its PLRU
        push          = accept & resolve_taken_i;
        pop           = ~fifo_empty & ~stall_fetch_i;
        push_entry.way    = pred_way_i;
        push_entry.index  = resolve_pc_i[INDEX_MSB:INDEX_LSB];
        push_entry.bia    = resolve_pc_i[BIA_MSB:BIA_LSB];
        push_entry.target = resolve_target_i;
    end

    // Next redirect state; the redirect PC is refreshed on every acceptance
    always_comb begin
        mispredict_d  = accept & is_mispredict;
        redirect_pc_d = redirect_pc_q;
        if (accept) begin
            redirect_pc_d = resolve_taken_i ? resolve_target_i
                                            : resolve_pc_i + ADDR_WIDTH'(4);
        end
    end

    // Registered flush pulse and redirect target
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (arst_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign resolve_ready_o = ~fifo_full;
    assign mispredict_o    = mispredict_q;
    assign redirect_pc_o   = redirect_pc_q;
    assign branch_taken_o  = ~fifo_empty;
    // Write fields read zero while empty so stale storage never shows after reset
    assign way_write_o     = fifo_empty ? '0 : head_entry.way;
    assign index_write_o   = fifo_empty ? '0 : head_entry.index;
    assign bia_write_o     = fifo_empty ? '0 : head_entry.bia;
    assign target_addr_o   = fifo_empty ? '0 : head_entry.target;

`ifdef BTB_UPD_PERF_EN
    logic [31:0] resolved_cnt_q, resolved_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    // Counter increments; both wrap naturally at 2^32
    always_comb begin
        resolved_cnt_d   = resolved_cnt_q + {31'd0, accept};
        mispredict_cnt_d = mispredict_cnt_q + {31'd0, mispredict_d};
    end

    // Performance counter registers
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            resolved_cnt_q   <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            resolved_cnt_q   <= resolved_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign resolved_cnt_o   = resolved_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`else
    assign resolved_cnt_o   = 32'd0;
    assign mispredict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_btb_update_unit.sv
// Bench for btb_update_unit: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the update path.
module tb_btb_update_unit;
    import btb_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst, stall, valid, taken, hit;
    logic [63:0] pc, target, ptarget;
    logic [1:0]  way;

    logic        ready, mispredict, branch_taken;
    logic [63:0] redirect_pc, target_addr;
    logic [1:0]  way_write, index_write;
    logic [59:0] bia_write;
    logic [31:0] resolved_cnt, mispredict_cnt;

    btb_update_unit dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .stall_fetch_i    (stall),
        .resolve_valid_i  (valid),
        .resolve_ready_o  (ready),
        .resolve_pc_i     (pc),
        .resolve_taken_i  (taken),
        .resolve_target_i (target),
        .pred_hit_i       (hit),
        .pred_way_i       (way),
        .pred_target_i    (ptarget),
        .mispredict_o     (mispredict),
        .redirect_pc_o    (redirect_pc),
        .branch_taken_o   (branch_taken),
        .way_write_o      (way_write),
        .index_write_o    (index_write),
        .bia_write_o      (bia_write),
        .target_addr_o    (target_addr),
        .resolved_cnt_o   (resolved_cnt),
        .mispredict_cnt_o (mispredict_cnt)
    );

    // ---------------- scoreboard / reference model ----------------
    localparam int UPD_W = $bits(btb_upd_t);
    logic [UPD_W-1:0] exp_q[$];
    logic             exp_mp;
    logic [63:0]      exp_redir;
    logic [31:0]      exp_res, exp_mis;
    bit               chk_redir;
    bit               after_rst;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Update the model with the inputs presented at this edge
    task automatic model_edge();
        btb_upd_t e;
        bit       acc, mis;
        if (arst) begin
            exp_q.delete();
            exp_mp    = 1'b0;
            exp_redir = '0;
            exp_res   = '0;
            exp_mis   = '0;
            chk_redir = 1'b1;
            after_rst = 1'b1;
        end else begin
            acc = valid && (exp_q.size() < DEPTH);
            mis = (taken != hit) || (taken && hit && (target != ptarget));
            if (exp_q.size() > 0 && !stall) void'(exp_q.pop_front());
            if (acc && taken) begin
                e.way    = way;
                e.index  = pc[3:2];
                e.bia    = pc[63:4];
                e.target = target;
                exp_q.push_back(e);
            end
            exp_mp = acc && mis;
            if (acc) exp_redir = taken ? target : pc + 64'd4;
            chk_redir = exp_mp;
            after_rst = 1'b0;
            exp_res = exp_res + (acc ? 32'd1 : 32'd0);
            exp_mis = exp_mis + ((acc && mis) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_outputs();
        btb_upd_t h;
        check_eq("ready", ready, (exp_q.size() < DEPTH) ? 64'd1 : 64'd0);
        check_eq("mispredict", mispredict, exp_mp);
        if (chk_redir) check_eq("redirect_pc", redirect_pc, exp_redir);
        check_eq("branch_taken", branch_taken, (exp_q.size() != 0) ? 64'd1 : 64'd0);
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check_eq("way_write", way_write, h.way);
            check_eq("index_write", index_write, h.index);
            check_eq("bia_write", bia_write, h.bia);
            check_eq("target_addr", target_addr, h.target);
        end else if (after_rst) begin
            check_eq("fields_rst", {way_write, index_write, bia_write} | target_addr, 64'd0);
        end
`ifdef BTB_UPD_PERF_EN
        check_eq("resolved_cnt", resolved_cnt, exp_res);
        check_eq("mispredict_cnt", mispredict_cnt, exp_mis);
`else
        check_eq("resolved_cnt", resolved_cnt, 64'd0);
        check_eq("mispredict_cnt", mispredict_cnt, 64'd0);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [63:0] p, input logic t,
                         input logic [63:0] tg, input logic h, input logic [1:0] w,
                         input logic [63:0] pt, input logic s);
        valid = v; pc = p; taken = t; target = tg;
        hit = h; way = w; ptarget = pt; stall = s;
    endtask

    task automatic idle(input logic s);
        drive(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 2'd0, 64'd0, s);
    endtask

    // One clock: model tracks the edge, outputs are checked on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        arst = 1'b1;
        idle(1'b0);
        step();
        step();
        arst = 1'b0;

        // Taken branch missed by the BTB
        drive(1'b1, 64'h1008, 1'b1, 64'h2000, 1'b0, 2'd2, 64'h0, 1'b0);
        step();
        check_eq("tp1_mispredict", mispredict, 64'd1);
        check_eq("tp1_redirect", redirect_pc, 64'h2000);
        check_eq("tp1_strobe", branch_taken, 64'd1);
        check_eq("tp1_index", index_write, 64'h2);
        check_eq("tp1_bia", bia_write, 64'h100);
        check_eq("tp1_way", way_write, 64'd2);
        check_eq("tp1_target", target_addr, 64'h2000);
        idle(1'b0);
        step();
        check_eq("tp1_popped", branch_taken, 64'd0);

        // Not-taken branch predicted taken
        drive(1'b1, 64'h3000, 1'b0, 64'h0, 1'b1, 2'd1, 64'h7000, 1'b0);
        step();
        check_eq("tp2_mispredict", mispredict, 64'd1);
        check_eq("tp2_redirect", redirect_pc, 64'h3004);
        check_eq("tp2_no_write", branch_taken, 64'd0);

        // Correct taken hit still refreshes the BTB
        drive(1'b1, 64'h4000, 1'b1, 64'h5000, 1'b1, 2'd3, 64'h5000, 1'b0);
        step();
        check_eq("tp3_no_mispredict", mispredict, 64'd0);
        check_eq("tp3_write", branch_taken, 64'd1);
        idle(1'b0);
        step();

        // Fill the queue under stall, then release while still presenting work
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h8000 + 64'(i * 16), 1'b1, 64'h9000 + 64'(i * 4), 1'b0,
                  2'(i), 64'h0, 1'b1);
            step();
        end
        check_eq("tp4_full", ready, 64'd0);
        drive(1'b1, 64'hA000, 1'b1, 64'hB000, 1'b0, 2'd1, 64'h0, 1'b1);
        step();
        stall = 1'b0;
        step();
        check_eq("tp4_release_blocked", mispredict, 64'd0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) step();

        // Fall-through wraps past the top of the address space
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b1, 2'd0, 64'h1234, 1'b0);
        step();
        check_eq("tp5_wrap_redirect", redirect_pc, 64'd0);
        check_eq("tp5_mispredict", mispredict, 64'd1);

        // Reset with entries pending
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'hC000 + 64'(i * 4), 1'b1, 64'hD000, 1'b0, 2'd0, 64'h0, 1'b1);
            step();
        end
        arst = 1'b1;
        step();
        check_eq("tp6_strobe", branch_taken, 64'd0);
        check_eq("tp6_ready", ready, 64'd1);
        check_eq("tp6_res_cnt", resolved_cnt, 64'd0);
        arst = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            arst  = ($urandom_range(0, 99) == 0);
            valid = ($urandom_range(0, 3) != 0);
            taken = $urandom_range(0, 1) == 1;
            hit   = $urandom_range(0, 1) == 1;
            way   = 2'($urandom_range(0, 3));
            pc    = {$urandom, $urandom};
            ptarget = {$urandom, $urandom};
            target  = ($urandom_range(0, 1) == 1) ? ptarget : {$urandom, $urandom};
            stall = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
